// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the MEM-stage controller (master) and the data memory (slave).
// Request fields are held stable by the master from D_Req rise until the D_Ack cycle.
interface mem_stage_ctrl_if;
  logic        D_Req;
  logic        D_We;
  logic [31:0] D_Addr;
  logic [31:0] D_Wdata;
  logic        D_Ack;
  logic [31:0] D_Rdata;

  modport master (
    output D_Req, D_We, D_Addr, D_Wdata,
    input  D_Ack, D_Rdata
  );

  modport slave (
    input  D_Req, D_We, D_Addr, D_Wdata,
    output D_Ack, D_Rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs loads/stores over a req/ack data bus, stalls upstream while busy.
// Define MEM_TIMEOUT_EN to abort an access after TIMEOUT busy cycles without D_Ack.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             M_Valid,
  input  logic             M_MemRead,
  input  logic             M_MemWrite,
  input  logic             M_RegWrite,
  input  logic             M_Overflow,
  input  logic [31:0]      M_ALUout,
  input  logic [31:0]      M_busB,
  input  logic [4:0]       M_Rw,
  mem_stage_ctrl_if.master dbus,
  output logic             Stall,
  output logic             W_Valid,
  output logic             W_RegWrite,
  output logic [4:0]       W_Rw,
  output logic [31:0]      W_Data,
  output logic             W_Exc
);

  if (TIMEOUT < 1 || TIMEOUT >= (1 << CNT_W)) begin : g_param_chk
    $error("mem_stage_ctrl: CNT_W too narrow for TIMEOUT");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Which write-back source is loaded at the coming edge.
  typedef enum logic [2:0] {
    WB_NONE  = 3'd0,
    WB_ALU   = 3'd1,
    WB_FAULT = 3'd2,
    WB_MEM   = 3'd3,
    WB_TMO   = 3'd4
  } wb_sel_t;

  state_t      r_state;
  state_t      w_state_nxt;
  wb_sel_t     w_wb_sel;

  logic        w_mem_op;
  logic        w_legal;
  logic        w_accept;
  logic        w_ack;
  logic        w_timeout;
  logic        w_done;

  logic        r_d_req;
  logic        r_d_we;
  logic [31:0] r_d_addr;
  logic [31:0] r_d_wdata;
  logic [4:0]  r_rw;
  logic        r_w_valid;
  logic        r_w_regwrite;
  logic [4:0]  r_w_rw;
  logic [31:0] r_w_data;
  logic        r_w_exc;

  assign w_mem_op = M_Valid & (M_MemRead | M_MemWrite);
  assign w_legal  = ~M_Overflow & (M_ALUout[1:0] == 2'b00);
  assign w_accept = (r_state == IDLE) & w_mem_op & w_legal;
  // D_Ack only counts in BUSY, so a late ack after reset or in IDLE is dropped.
  assign w_ack    = (r_state == BUSY) & dbus.D_Ack;
  assign w_done   = w_ack | w_timeout;

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  assign w_timeout = (r_state == BUSY) & ~dbus.D_Ack &
                     (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if ((r_state == BUSY) && !dbus.D_Ack && !w_timeout) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = BUSY;
      BUSY:    if (w_done)   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stall is released in the completing cycle so upstream advances on the same edge.
  always_comb begin
    Stall    = 1'b0;
    w_wb_sel = WB_NONE;
    case (r_state)
      IDLE: begin
        if (M_Valid) begin
          if (!w_mem_op) begin
            w_wb_sel = WB_ALU;
          end else if (!w_legal) begin
            w_wb_sel = WB_FAULT;
          end else begin
            Stall = 1'b1;
          end
        end
      end
      BUSY: begin
        if (dbus.D_Ack) begin
          w_wb_sel = WB_MEM;
        end else if (w_timeout) begin
          w_wb_sel = WB_TMO;
        end else begin
          Stall = 1'b1;
        end
      end
      default: begin
        Stall    = 1'b0;
        w_wb_sel = WB_NONE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_d_req      <= 1'b0;
      r_d_we       <= 1'b0;
      r_d_addr     <= '0;
      r_d_wdata    <= '0;
      r_rw         <= '0;
      r_w_valid    <= 1'b0;
      r_w_regwrite <= 1'b0;
      r_w_rw       <= '0;
      r_w_data     <= '0;
      r_w_exc      <= 1'b0;
    end else begin
      r_w_valid    <= 1'b0;
      r_w_regwrite <= 1'b0;
      r_w_exc      <= 1'b0;
      if (w_accept) begin
        r_d_req   <= 1'b1;
        r_d_we    <= M_MemWrite;
        r_d_addr  <= M_ALUout;
        r_d_wdata <= M_busB;
        r_rw      <= M_Rw;
      end
      case (w_wb_sel)
        WB_ALU: begin
          r_w_valid    <= 1'b1;
          r_w_regwrite <= M_RegWrite & ~M_Overflow & (M_Rw != 5'd0);
          r_w_rw       <= M_Rw;
          r_w_data     <= M_ALUout;
          r_w_exc      <= M_Overflow;
        end
        WB_FAULT: begin
          r_w_valid <= 1'b1;
          r_w_rw    <= M_Rw;
          r_w_data  <= M_ALUout;
          r_w_exc   <= 1'b1;
        end
        WB_MEM: begin
          r_d_req   <= 1'b0;
          r_w_valid <= 1'b1;
          r_w_rw    <= r_rw;
          if (r_d_we) begin
            r_w_data <= r_d_addr;
          end else begin
            r_w_data     <= dbus.D_Rdata;
            r_w_regwrite <= (r_rw != 5'd0);
          end
        end
        WB_TMO: begin
          r_d_req   <= 1'b0;
          r_w_valid <= 1'b1;
          r_w_rw    <= r_rw;
          r_w_data  <= r_d_addr;
          r_w_exc   <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign dbus.D_Req   = r_d_req;
  assign dbus.D_We    = r_d_we;
  assign dbus.D_Addr  = r_d_addr;
  assign dbus.D_Wdata = r_d_wdata;

  assign W_Valid    = r_w_valid;
  assign W_RegWrite = r_w_regwrite;
  assign W_Rw       = r_w_rw;
  assign W_Data     = r_w_data;
  assign W_Exc      = r_w_exc;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed cases plus a random instruction stream
// checked against a word-addressed memory model; timeout case runs when MEM_TIMEOUT_EN is defined.
module tb_mem_stage_ctrl;
  localparam int TB_TIMEOUT = 4;

  typedef struct {
    logic        rwe;
    logic [4:0]  rw;
    logic [31:0] data;
    logic        exc;
    bit          chk_rw;
    bit          chk_data;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  logic        Clk;
  logic        Reset;
  logic        M_Valid, M_MemRead, M_MemWrite, M_RegWrite, M_Overflow;
  logic [31:0] M_ALUout, M_busB;
  logic [4:0]  M_Rw;
  logic        Stall, W_Valid, W_RegWrite, W_Exc;
  logic [4:0]  W_Rw;
  logic [31:0] W_Data;

  logic        r_ack, m_ack;
  logic [31:0] r_rdata, m_rdata;

  int n_checks;
  int n_fail;
  bit mon_en;
  int fixed_lat;
  int wait_cnt;
  logic prev_req;
  bus_t cur_bus;

  wb_t  wbq[$];
  bus_t busq[$];
  logic [31:0] model_mem[logic [31:0]];
  logic [31:0] bus_mem[logic [31:0]];

  mem_stage_ctrl_if dbus();

  assign dbus.D_Ack   = r_ack | m_ack;
  assign dbus.D_Rdata = m_ack ? m_rdata : r_rdata;

  mem_stage_ctrl #(.TIMEOUT(TB_TIMEOUT), .CNT_W(5)) dut (
    .Clk(Clk), .Reset(Reset),
    .M_Valid(M_Valid), .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite),
    .M_RegWrite(M_RegWrite), .M_Overflow(M_Overflow),
    .M_ALUout(M_ALUout), .M_busB(M_busB), .M_Rw(M_Rw),
    .dbus(dbus),
    .Stall(Stall), .W_Valid(W_Valid), .W_RegWrite(W_RegWrite),
    .W_Rw(W_Rw), .W_Data(W_Data), .W_Exc(W_Exc)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory responder: acks the current request after fixed_lat extra BUSY cycles.
  initial begin
    r_ack = 1'b0;
    r_rdata = '0;
    wait_cnt = -1;
    forever begin
      @(posedge Clk);
      #1;
      r_ack = 1'b0;
      r_rdata = $urandom;
      if (dbus.D_Req === 1'b1 && fixed_lat >= 0) begin
        if (wait_cnt < 0) wait_cnt = fixed_lat;
        if (wait_cnt == 0) begin
          r_ack = 1'b1;
          if (dbus.D_We) bus_mem[dbus.D_Addr] = dbus.D_Wdata;
          else r_rdata = bus_rd(dbus.D_Addr);
          wait_cnt = -1;
        end else begin
          wait_cnt--;
        end
      end else if (dbus.D_Req !== 1'b1) begin
        wait_cnt = -1;
      end
    end
  end

  // Write-back monitor.
  always @(negedge Clk) begin
    wb_t e;
    if (mon_en && W_Valid === 1'b1) begin
      n_checks++;
      if (wbq.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got W_Valid=1 data=%h, expected no write-back", W_Data);
      end else begin
        e = wbq.pop_front();
        if (W_RegWrite !== e.rwe || W_Exc !== e.exc ||
            (e.chk_rw && W_Rw !== e.rw) || (e.chk_data && W_Data !== e.data)) begin
          n_fail++;
          $display("FAIL wb: got rwe=%b rw=%0d data=%h exc=%b, expected rwe=%b rw=%0d data=%h exc=%b",
                   W_RegWrite, W_Rw, W_Data, W_Exc, e.rwe, e.rw, e.data, e.exc);
        end
      end
    end
  end

  // Bus monitor: request contents on rise, then stability until it drops.
  always @(negedge Clk) begin
    if (mon_en && dbus.D_Req === 1'b1) begin
      n_checks++;
      if (prev_req !== 1'b1) begin
        if (busq.size() == 0) begin
          n_fail++;
          $display("FAIL bus_unexpected: got D_Req=1 addr=%h, expected no request", dbus.D_Addr);
        end else begin
          cur_bus = busq.pop_front();
          if (dbus.D_Addr !== cur_bus.addr || dbus.D_We !== cur_bus.we || dbus.D_Wdata !== cur_bus.wdata) begin
            n_fail++;
            $display("FAIL bus_req: got addr=%h we=%b wdata=%h, expected addr=%h we=%b wdata=%h",
                     dbus.D_Addr, dbus.D_We, dbus.D_Wdata, cur_bus.addr, cur_bus.we, cur_bus.wdata);
          end
        end
      end else if (dbus.D_Addr !== cur_bus.addr || dbus.D_We !== cur_bus.we || dbus.D_Wdata !== cur_bus.wdata) begin
        n_fail++;
        $display("FAIL bus_hold: got addr=%h we=%b wdata=%h, expected addr=%h we=%b wdata=%h",
                 dbus.D_Addr, dbus.D_We, dbus.D_Wdata, cur_bus.addr, cur_bus.we, cur_bus.wdata);
      end
    end
    prev_req = dbus.D_Req;
  end

  // Presents one instruction (called just after a posedge), holds it while Stall, checks stall count.
  // lat < 0 means the memory never acks.
  task automatic issue(input string name, input logic v, input logic rd, input logic wr,
                       input logic rwe, input logic ovf, input logic [31:0] alu,
                       input logic [31:0] busb, input logic [4:0] rw, input int lat);
    wb_t  e;
    bus_t b;
    bit   memop, legal, done;
    int   exp_st, st;
    memop = v && (rd || wr);
    legal = !ovf && (alu[1:0] == 2'b00);
    M_Valid = v; M_MemRead = rd; M_MemWrite = wr; M_RegWrite = rwe;
    M_Overflow = ovf; M_ALUout = alu; M_busB = busb; M_Rw = rw;
    fixed_lat = lat;
    exp_st = 0;
    e.rw = rw; e.chk_rw = 1'b0; e.chk_data = 1'b1; e.data = alu; e.exc = 1'b0; e.rwe = 1'b0;
    if (v && !memop) begin
      e.rwe = rwe && !ovf && (rw != 5'd0);
      e.exc = ovf;
      e.chk_rw = 1'b1;
      wbq.push_back(e);
    end else if (memop && !legal) begin
      e.exc = 1'b1;
      wbq.push_back(e);
    end else if (memop) begin
      b.addr = alu; b.we = wr; b.wdata = busb;
      busq.push_back(b);
      if (lat < 0) begin
        e.exc = 1'b1;
        e.chk_data = 1'b0;
        exp_st = TB_TIMEOUT;
      end else if (wr) begin
        model_mem[alu] = busb;
        exp_st = 1 + lat;
      end else begin
        e.data = model_rd(alu);
        e.rwe = (rw != 5'd0);
        e.chk_rw = 1'b1;
        exp_st = 1 + lat;
      end
      wbq.push_back(e);
    end
    st = 0;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge Clk);
      if (Stall === 1'b0) done = 1'b1;
      else st++;
      @(posedge Clk);
      #1;
    end
    M_Valid = 1'b0;
    if (!done) chk({name, "_hang"}, 32'(done), 32'd1);
    chk({name, "_stall"}, 32'(st), 32'(exp_st));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_t b;
    int k, lat;
    logic [31:0] a;
    n_checks = 0; n_fail = 0; mon_en = 1'b0; fixed_lat = 0; prev_req = 1'b0;
    m_ack = 1'b0; m_rdata = '0;
    Reset = 1'b1;
    M_Valid = 0; M_MemRead = 0; M_MemWrite = 0; M_RegWrite = 0; M_Overflow = 0;
    M_ALUout = '0; M_busB = '0; M_Rw = '0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_D_Req", 32'(dbus.D_Req), 32'd0);
    chk("rst_D_We", 32'(dbus.D_We), 32'd0);
    chk("rst_D_Addr", dbus.D_Addr, 32'd0);
    chk("rst_D_Wdata", dbus.D_Wdata, 32'd0);
    chk("rst_W_Valid", 32'(W_Valid), 32'd0);
    chk("rst_W_RegWrite", 32'(W_RegWrite), 32'd0);
    chk("rst_W_Rw", 32'(W_Rw), 32'd0);
    chk("rst_W_Data", W_Data, 32'd0);
    chk("rst_W_Exc", 32'(W_Exc), 32'd0);
    chk("rst_Stall", 32'(Stall), 32'd0);
    mon_en = 1'b1;
    @(posedge Clk);
    #1;

    issue("alu", 1, 0, 0, 1, 0, 32'h0000_1234, 32'h0, 5'd5, 0);
    model_mem[32'h40] = 32'hDEAD_BEEF;
    bus_mem[32'h40]   = 32'hDEAD_BEEF;
    issue("load_lat3", 1, 1, 0, 1, 0, 32'h40, 32'h1111_2222, 5'd7, 3);
    issue("store_lat0", 1, 0, 1, 0, 0, 32'h44, 32'hCAFE_0001, 5'd3, 0);
    issue("load_misaligned", 1, 1, 0, 1, 0, 32'h42, 32'h0, 5'd9, 0);
    issue("load_overflow", 1, 1, 0, 1, 1, 32'h48, 32'h0, 5'd10, 0);
    issue("alu_overflow", 1, 0, 0, 1, 1, 32'h7FFF_FFFC, 32'h0, 5'd11, 0);
    issue("alu_rw0", 1, 0, 0, 1, 0, 32'hABCD_0000, 32'h0, 5'd0, 0);
    issue("load_rw0", 1, 1, 0, 1, 0, 32'h44, 32'h0, 5'd0, 1);
    issue("bubble", 0, 0, 0, 1, 0, 32'h5555_5555, 32'h0, 5'd4, 0);
    issue("load_back", 1, 1, 0, 1, 0, 32'h44, 32'h0, 5'd12, 2);

    // Reset during BUSY, then a stray ack: nothing may reach write-back.
    fixed_lat = -1;
    M_Valid = 1; M_MemRead = 1; M_MemWrite = 0; M_RegWrite = 1; M_Overflow = 0;
    M_ALUout = 32'h80; M_busB = 32'h0; M_Rw = 5'd6;
    b.addr = 32'h80; b.we = 1'b0; b.wdata = 32'h0;
    busq.push_back(b);
    repeat (2) begin
      @(posedge Clk);
      #1;
    end
    Reset = 1'b1;
    M_Valid = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    m_ack = 1'b1;
    m_rdata = 32'h0BAD_0BAD;
    @(negedge Clk);
    chk("rstbusy_D_Req", 32'(dbus.D_Req), 32'd0);
    chk("rstbusy_W_Valid", 32'(W_Valid), 32'd0);
    chk("rstbusy_W_RegWrite", 32'(W_RegWrite), 32'd0);
    chk("rstbusy_W_Exc", 32'(W_Exc), 32'd0);
    chk("rstbusy_W_Data", W_Data, 32'd0);
    chk("rstbusy_W_Rw", 32'(W_Rw), 32'd0);
    chk("rstbusy_Stall", 32'(Stall), 32'd0);
    @(posedge Clk);
    #1;
    m_ack = 1'b0;
    @(negedge Clk);
    chk("lateack_W_Valid", 32'(W_Valid), 32'd0);
    chk("lateack_D_Req", 32'(dbus.D_Req), 32'd0);
    @(posedge Clk);
    #1;

`ifdef MEM_TIMEOUT_EN
    issue("timeout", 1, 1, 0, 1, 0, 32'h88, 32'h0, 5'd8, -1);
    @(negedge Clk);
    chk("timeout_D_Req", 32'(dbus.D_Req), 32'd0);
    chk("timeout_Stall", 32'(Stall), 32'd0);
    @(posedge Clk);
    #1;
    issue("after_timeout", 1, 0, 1, 0, 0, 32'h8C, 32'h1357_9BDF, 5'd1, 3);
`endif

    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 9);
      lat = $urandom_range(0, 3);
      a = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
      if (k < 2)
        issue("rnd_bubble", 0, 0, 0, 1'($urandom), 0, $urandom, $urandom, 5'($urandom), lat);
      else if (k < 5)
        issue("rnd_alu", 1, 0, 0, 1'($urandom), ($urandom_range(0, 7) == 0), $urandom, $urandom,
              5'($urandom), lat);
      else if (k < 8)
        issue("rnd_load", 1, 1, 0, 1, ($urandom_range(0, 7) == 0), a, $urandom, 5'($urandom), lat);
      else
        issue("rnd_store", 1, 0, 1, 0, ($urandom_range(0, 7) == 0), a, $urandom, 5'($urandom), lat);
    end

    repeat (3) @(negedge Clk);
    chk("drain_wbq", 32'(wbq.size()), 32'd0);
    chk("drain_busq", 32'(busq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller on the consumer side of the EX/MEM pipeline register.
- Takes the registered execute results (address, store data, destination register, overflow flag), runs loads and stores against a multi-cycle data-memory bus with a req/ack handshake, and stalls the pipeline while an access is outstanding.
- Drives the MEM/WB-side outputs: write-back data, destination register and an exception flag.

Parameters:
- TIMEOUT, 16: maximum BUSY cycles without D_Ack before abort (used only with MEM_TIMEOUT_EN).
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- M_Valid  in  1  instruction in MEM stage is valid.
- M_MemRead  in  1  load (word).
- M_MemWrite  in  1  store (word).
- M_RegWrite  in  1  instruction writes a register.
- M_Overflow  in  1  ALU overflow from EX.
- M_ALUout  in  32  effective address, or ALU result.
- M_busB  in  32  store data.
- M_Rw  in  5  destination register.
- D_Req  out  1  memory request.
- D_We  out  1  1 = write.
- D_Addr  out  32  word address (byte address, low 2 bits always 0).
- D_Wdata  out  32  store data.
- D_Ack  in  1  memory completes request this cycle.
- D_Rdata  in  32  load data, valid with D_Ack.
- Stall  out  1  combinational; upstream holds EX/MEM and earlier stages while 1.
- W_Valid  out  1  write-back slot valid.
- W_RegWrite  out  1  register write enable.
- W_Rw  out  5  destination register.
- W_Data  out  32  write-back data.
- W_Exc  out  1  exception (overflow, misaligned, timeout).

Behaviour:
- Reset: all registered outputs go to 0 (D_Req, D_We, D_Addr, D_Wdata, W_*); state = IDLE; counter = 0.
- Reset wins over every other event, including an access in progress. D_Req drops at that edge. Any late D_Ack is ignored, because D_Ack is sampled only in BUSY.
- States: IDLE, BUSY.
- mem_op = M_Valid & (M_MemRead | M_MemWrite). legal = !M_Overflow & (M_ALUout[1:0] == 0).
- IDLE, M_Valid = 0: next edge W_Valid = 0, W_RegWrite = 0, W_Exc = 0 (bubble).
- IDLE, valid non-memory instruction:
  - Next edge: W_Valid = 1, W_Data = M_ALUout, W_Rw = M_Rw.
  - W_RegWrite = M_RegWrite & !M_Overflow & (M_Rw != 0); W_Exc = M_Overflow.
  - Latency 1 cycle; Stall = 0.
- IDLE, mem_op & !legal:
  - No bus access. Next edge: W_Valid = 1, W_Exc = 1, W_RegWrite = 0, W_Data = M_ALUout.
  - Stall = 0.
- IDLE, mem_op & legal:
  - Stall = 1 this cycle.
  - Next edge: latch D_Addr = M_ALUout, D_Wdata = M_busB, D_We = M_MemWrite, the destination register and the load flag; set D_Req = 1; W_Valid = 0; go to BUSY.
- BUSY: Stall = M_Valid inputs ignored; D_Req, D_Addr, D_We, D_Wdata held stable until D_Ack.
  - Stall = !D_Ack.
  - W_Valid = 0 each edge with no ack.
- BUSY & D_Ack:
  - Stall = 0 this cycle, so upstream advances on the same edge.
  - Next edge: D_Req = 0; go to IDLE; W_Valid = 1; W_Exc = 0.
  - Load: W_Data = D_Rdata, W_RegWrite = (Rw != 0).
  - Store: W_RegWrite = 0, W_Data = D_Addr.
- Minimum memory-instruction occupancy is 2 cycles (accept cycle plus ack in the first BUSY cycle).
- D_Ack in IDLE is ignored.
- Back-to-back memory ops: the next op is accepted in the IDLE cycle that follows the return edge.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - The counter clears on entering BUSY and increments each BUSY cycle without D_Ack.
  - When the counter reaches TIMEOUT-1 with no ack: Stall = 0 that cycle. Next edge: D_Req = 0, IDLE, W_Valid = 1, W_Exc = 1, W_RegWrite = 0.
  - D_Ack in that same cycle takes priority (normal completion).
- MEM_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; TIMEOUT and CNT_W are unused.

Test Plan:
- ALU instruction, M_ALUout = 0x0000_1234, M_Rw = 5, M_RegWrite = 1 -> next edge W_Valid = 1, W_Data = 0x1234, W_RegWrite = 1, Stall never 1.
- Load, address 0x40, D_Ack 3 cycles after D_Req with D_Rdata = 0xDEADBEEF -> Stall high 4 cycles, D_Addr = 0x40 held, then W_Data = 0xDEADBEEF, W_Rw correct, W_RegWrite = 1.
- Store, address 0x44, busB = 0xCAFE0001, immediate ack -> D_We = 1, D_Wdata = 0xCAFE0001, 2-cycle occupancy, W_RegWrite = 0.
- Misaligned load at 0x42, and a load with M_Overflow = 1 -> D_Req never asserted, W_Exc = 1, W_RegWrite = 0, no stall.
- Reset asserted in BUSY, then D_Ack pulsed the following cycle -> D_Req = 0 and all W_* = 0 after the reset edge; ack produces no write-back.
- With MEM_TIMEOUT_EN, TIMEOUT = 4, no ack -> exactly 4 BUSY cycles, then W_Exc = 1, D_Req = 0, Stall released. Load with Rw = 0 -> W_RegWrite = 0.
